// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default bit timing, data width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // 50 MHz system clock / 115200 baud.
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;
  localparam int UART_DATA_BITS            = 8;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_IDLE = 3'd5
  } rx_state_t;

  // Even parity: the data bits plus the parity bit hold an even number of ones.
  function automatic logic even_parity_ok(input logic [UART_DATA_BITS-1:0] dat,
                                          input logic                      par_bit);
    return ~((^dat) ^ par_bit);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with occupancy count.
// Latency: a write is visible at rd_dat on the clock after it is accepted; pops take effect at the edge.
// Backpressure: wr_rdy low when full unless a pop happens in the same cycle; pops while empty are ignored.
// Ports: clk, rst_n (async active-low) | wr_vld/wr_dat/wr_rdy write side
//        | rd_rdy pop strobe, rd_dat head (0 when empty) | count, full, empty status.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic                     wr_rdy,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign count  = count_q;
  // A pop frees the slot the write needs, so a full FIFO still accepts when popped.
  assign wr_rdy = ~full | rd_rdy;
  assign do_rd  = rd_rdy & ~empty;
  assign do_wr  = wr_vld & (~full | do_rd);
  assign rd_dat = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap by natural overflow.
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observable through count.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receive front end: pin synchroniser, 8N1 deserialiser, FWFT byte FIFO.
// Latency: 3 clocks pin-to-detect; byte at rdData one clock after the stop-bit sample.
// Backpressure: none toward the line; a byte completing into a full FIFO without a pop is dropped, overrun set.
// Ports: CLK, RST (async active-low) | uartRxPin raw line | rdEn pop, rdData/empty/full/count FIFO view
//        | overrun sticky, cleared by clrOverrun | frameErr/parityErr one-clock error pulses.
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            uartRxPin,
  input  logic                            rdEn,
  output logic [UART_DATA_BITS-1:0]       rdData,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            overrun,
  input  logic                            clrOverrun,
  output logic                            frameErr,
  output logic                            parityErr
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  // Synchroniser resets to the idle (high) line level so reset never fakes a start bit.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uartRxPin;
      rx_s_q    <= rx_meta_q;
    end
  end

  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      push_vld, fifo_wr_rdy, bit_tick;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d;
  logic                      parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push_vld    = 1'b0;
    bit_tick    = (bit_cnt_q == FULL_M1);
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      RX_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s_q) state_d = RX_START;
      end
      RX_START: begin
        // Re-check mid start bit; a high line here was a glitch.
        if (bit_cnt_q == HALF_M1) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_tick) begin
          bit_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (bit_tick) begin
          bit_cnt_d = '0;
          par_bad_d = ~even_parity_ok(shift_q, rx_s_q);
          state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (bit_tick) begin
          bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
          push_vld     = rx_s_q & ~par_bad_q;
`else
          push_vld     = rx_s_q;
`endif
          if (rx_s_q) begin
            state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        // Hold off through a break so a stuck-low line is not parsed as 0x00 frames.
        bit_cnt_d = '0;
        if (rx_s_q) state_d = RX_IDLE;
      end
      default: begin
        bit_cnt_d = '0;
        state_d   = RX_IDLE;
      end
    endcase

    // Set wins over clear when both land in the same cycle.
    overrun_d = overrun_q;
    if (clrOverrun) overrun_d = 1'b0;
    if (push_vld && !fifo_wr_rdy) overrun_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parityErr = parity_err_q;
`else
  assign parityErr = 1'b0;
`endif

  assign frameErr = frame_err_q;
  assign overrun  = overrun_q;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk    (CLK),
    .rst_n  (RST),
    .wr_vld (push_vld),
    .wr_dat (shift_q),
    .wr_rdy (fifo_wr_rdy),
    .rd_rdy (rdEn),
    .rd_dat (rdData),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end for the UART console path. It sits between the `uartRxPin` board pin and the memory-mapped UART registers in the MMU. The block synchronises the pin, deserialises 8N1 frames, and buffers received bytes in a first-word-fall-through FIFO. The MMU pops bytes with a single-cycle strobe on a load from the RX data address.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: system clocks per bit (50 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, default 16: power of two, ≥ 2.

Ports (clock and reset first):
- `CLK`  in  1  system clock; one clock for the whole block.
- `RST`  in  1  reset, asynchronous, active-low.
- `uartRxPin`  in  1  raw serial line, idle high, asynchronous to `CLK`.
- `rdEn`  in  1  pop strobe from MMU; ignored when `empty`.
- `rdData`  out  8  FIFO head byte; valid while `!empty`.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `count`  out  $clog2(FIFO_DEPTH)+1  bytes held.
- `overrun`  out  1  sticky: a completed byte was dropped because the FIFO was full.
- `clrOverrun`  in  1  clears `overrun`.
- `frameErr`  out  1  one-cycle pulse when the stop bit is sampled low.
- `parityErr`  out  1  one-cycle pulse on parity mismatch (see Configuration).

## Operation
- Input path: 2-FF synchronizer with `uartRxPin` reset value 1. All logic uses only the synchronized bit `rxS`.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE. A bit-time counter `bitCnt` and a bit index `bitIdx` (0..7) drive it.
- IDLE: on `rxS` = 0, clear `bitCnt` and go to START.
- START: at `bitCnt` = CLKS_PER_BIT/2 − 1, sample `rxS`.
  - If 1 (glitch), return to IDLE.
  - If 0, clear `bitCnt` and go to DATA.
- DATA: every CLKS_PER_BIT clocks, sample `rxS` into shift register bit `bitIdx`, LSB first. After bit 7, go to PARITY (if enabled) or STOP.
- STOP: after CLKS_PER_BIT clocks, sample `rxS`.
  - If 1 and no parity error: push the byte and go to IDLE.
  - If 0: pulse `frameErr`, drop the byte, and go to WAIT_IDLE.
- WAIT_IDLE: stay until `rxS` = 1, so a break condition is not re-parsed as frames. Then go to IDLE.
- FIFO push and pop rules:
  - Push when full with no pop: byte dropped and `overrun` set.
  - Push and pop in the same cycle when full: both happen and `count` is unchanged.
  - Push and pop in the same cycle when empty: only the push happens.
- `rdEn` on empty: no effect. Pointers wrap modulo `FIFO_DEPTH`.
- `overrun`: if `clrOverrun` and a new overrun happen in the same cycle, set wins.

## Timing
- Reset values:
  - `empty` = 1.
  - `full`, `count`, `overrun`, `frameErr`, `parityErr` = 0.
  - `rdData` = 0.
  - FSM in IDLE, pointers 0.
- Reset asserted mid-frame: the partial byte and the FIFO contents are discarded.
- Pin-to-detect latency: 2 clocks (synchronizer) + 1 (IDLE → START).
- The stop-bit sample occurs 9.5 bit times after the detected falling edge (10.5 with parity).
- `empty` deasserts and `count` increments on the clock after the stop sample. `rdData` shows the head with no further latency.
- Pop: `rdEn` high on edge N gives the next head, `count` − 1, and updated `empty` after edge N.
- `frameErr` and `parityErr` are high for exactly one clock, aligned with the cycle the push would have occurred.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP; even parity expected.
  - On mismatch, `parityErr` pulses and the byte is dropped; STOP is still checked.
- Not defined:
  - Pure 8N1 framing, no PARITY state.
  - `parityErr` tied to 0.

## Structure
- Shared package `uart_pkg` holds:
  - `rx_state_t` enum.
  - `UART_DEFAULT_CLKS_PER_BIT` = 434.
  - `UART_DATA_BITS` = 8.
- Sub-module `sync_fifo`: parameterised width and depth, FWFT, with count, full and empty. It is reusable by a future TX path.

## Test plan
Bench runs with `CLKS_PER_BIT` = 8 and `FIFO_DEPTH` = 4.
- Send frame 0xA5, read with `rdEn` → `rdData` = 0xA5 one clock after the stop sample; `count` goes 1 → 0; `empty` = 1 after the pop.
- Low glitch of 3 clocks on idle line → no push, FSM back in IDLE, `frameErr` = 0.
- Send 0x3C with the stop bit driven low → one `frameErr` pulse, FIFO stays empty. A new frame 0x11 after the line returns high is received correctly.
- Send 5 bytes 0x01..0x05 with no reads → `full` = 1, `count` = 4, `overrun` = 1; reads return 0x01..0x04. Then `clrOverrun` → `overrun` = 0.
- With FIFO full, a stop-bit push coincides with `rdEn` → `count` stays 4 and `overrun` stays 0.
- `RST` pulsed low during DATA of 0x77 → all outputs at reset values. The next frame 0x42 is received intact.
- (`UART_RX_PARITY_EN`) send 0x07 with parity bit 0 → `parityErr` pulse and no push. Send 0x07 with parity bit 1 → pushed.
